// File: rtl/lif_pkg.sv
// lif_pkg
// Shared definitions for the time-multiplexed LIF neuron scheduler.
// Holds the default neuron count and datapath width, and the state
// encoding of the step sequencer.
//   DEF_N_NEURONS : default number of neurons sharing one update datapath
//   DEF_V_WIDTH   : default width of membrane potential, current and threshold
//   lif_state_e   : sequencer states (idle, per-neuron update, result publish)

package lif_pkg;

  localparam int DEF_N_NEURONS = 8;
  localparam int DEF_V_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// lif_update
// Combinational leak / integrate / saturate / compare for one neuron.
// The scheduler owns a single instance and feeds it one neuron per cycle.
// Ports:
//   v      : stored membrane potential of the neuron being updated
//   cur    : input current for that neuron
//   thr    : firing threshold for the current step
//   v_next : potential to store back (0 when the neuron fires)
//   fire   : high when the saturated sum reaches the threshold

module lif_update
  import lif_pkg::*;
#(
  parameter int V_WIDTH = DEF_V_WIDTH
) (
  input  logic [V_WIDTH-1:0] v,
  input  logic [V_WIDTH-1:0] cur,
  input  logic [V_WIDTH-1:0] thr,
  output logic [V_WIDTH-1:0] v_next,
  output logic               fire
);

  logic [V_WIDTH:0]   sum;
  logic [V_WIDTH-1:0] sat;

  // Leak halves the old potential; one extra bit holds the carry of the
  // integration so an overflow can be clamped to full scale rather than
  // wrapping back to a small value.
  always_comb begin
    sum    = {2'b00, v[V_WIDTH-1:1]} + {1'b0, cur};
    sat    = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
    fire   = (sat >= thr);
    v_next = fire ? '0 : sat;
  end

endmodule

// File: rtl/lif_tm_scheduler.sv
// lif_tm_scheduler
// Steps a bank of leaky integrate-and-fire neurons through one timestep,
// updating one neuron per clock through a shared lif_update datapath.
// A step takes N_NEURONS update cycles plus one publish cycle plus one
// return-to-idle cycle, so a new step can be accepted every N_NEURONS+2 cycles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   step_valid  : request one timestep
//   step_ready  : high only while idle; a step starts on valid && ready
//   threshold   : firing threshold, captured when a step is accepted
//   cur_idx     : neuron whose input current is needed this cycle (0 when not updating)
//   cur_in      : input current for neuron cur_idx, used in the same cycle
//   spike_vec   : spikes of the last completed step, bit k = neuron k
//   spike_valid : one-cycle pulse when spike_vec is refreshed
//   busy        : high while a step is in progress
//   rd_idx      : debug read index
//   rd_state    : stored membrane potential of neuron rd_idx (combinational)

module lif_tm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int V_WIDTH   = DEF_V_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [V_WIDTH-1:0]           threshold,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic [V_WIDTH-1:0]           cur_in,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic                         spike_valid,
  output logic                         busy,
  input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
  output logic [V_WIDTH-1:0]           rd_state
);

  localparam int                IDX_W    = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NEURONS - 1);

  lif_state_e           state;
  logic [IDX_W-1:0]     idx;
  logic [V_WIDTH-1:0]   thr_q;
  logic [N_NEURONS-1:0] acc;
  logic [N_NEURONS-1:0] acc_next;
  logic [V_WIDTH-1:0]   v_mem [N_NEURONS];

  logic [V_WIDTH-1:0]   v_cur;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  assign v_cur    = v_mem[idx];
  assign rd_state = v_mem[rd_idx];

  // idx is forced back to 0 whenever the sequencer leaves UPDATE, so it can
  // drive the current-request index directly without extra gating.
  assign cur_idx  = idx;

  lif_update #(
    .V_WIDTH (V_WIDTH)
  ) u_update (
    .v      (v_cur),
    .cur    (cur_in),
    .thr    (thr_q),
    .v_next (v_next),
    .fire   (fire)
  );

  // Spike accumulator with the neuron being updated this cycle folded in.
  // The last neuron's spike must reach spike_vec on the same edge that
  // enters DONE, so the published vector is taken from this value.
  always_comb begin
    acc_next = acc;
    if (fire) begin
      acc_next[idx] = 1'b1;
    end
  end

  // Step sequencer. Handshake and status outputs are registered alongside
  // the state so they change exactly on state transitions. A reset in the
  // middle of a step simply lands here and discards everything, which is
  // why no partial spike result can ever be published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      thr_q       <= '0;
      acc         <= '0;
      spike_vec   <= '0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      step_ready  <= 1'b1;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_valid) begin
            state      <= ST_UPDATE;
            thr_q      <= threshold;
            idx        <= '0;
            acc        <= '0;
            step_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end

        ST_UPDATE: begin
          v_mem[idx] <= v_next;
          acc        <= acc_next;
          if (idx == LAST_IDX) begin
            idx         <= '0;
            state       <= ST_DONE;
            spike_vec   <= acc_next;
            spike_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_DONE: begin
          state       <= ST_IDLE;
          spike_valid <= 1'b0;
          busy        <= 1'b0;
          step_ready  <= 1'b1;
        end

        default: begin
          state       <= ST_IDLE;
          idx         <= '0;
          spike_valid <= 1'b0;
          busy        <= 1'b0;
          step_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
